// File: rtl/hilo_alu_control.sv
// rtl/hilo_alu_control.sv - decode-stage ALU op decode, HI/LO registers and iterative mul/div sequencer
module hilo_alu_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             issue,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [3:0]       alu_op,
    output logic             stall,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             div_zero
);

    localparam logic [3:0] ALU_undef   = 4'hF;
    localparam logic [3:0] ALU_add     = 4'h1;
    localparam logic [3:0] ALU_sub     = 4'h2;
    localparam logic [3:0] ALU_AND     = 4'h3;
    localparam logic [3:0] ALU_OR      = 4'h4;
    localparam logic [3:0] ALU_XOR     = 4'h5;
    localparam logic [3:0] ALU_NOR     = 4'h6;
    localparam logic [3:0] ALU_slt     = 4'h7;
    localparam logic [3:0] ALU_sltu    = 4'h8;
    localparam logic [3:0] ALU_sll     = 4'h9;
    localparam logic [3:0] ALU_srl     = 4'hA;
    localparam logic [3:0] ALU_sra     = 4'hB;
    localparam logic [3:0] ALU_rs_pass = 4'hC;
    localparam logic [3:0] ALU_slli    = 4'hD;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic dec_hilo, dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
    logic dec_mul, dec_div, dec_signed;
    logic accept;

    always_comb begin
        alu_op     = ALU_undef;
        dec_hilo   = 1'b0;
        dec_mfhi   = 1'b0;
        dec_mflo   = 1'b0;
        dec_mthi   = 1'b0;
        dec_mtlo   = 1'b0;
        dec_mul    = 1'b0;
        dec_div    = 1'b0;
        dec_signed = 1'b0;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                FN_ADD, FN_ADDU: alu_op = ALU_add;
                FN_SUB, FN_SUBU: alu_op = ALU_sub;
                FN_AND:          alu_op = ALU_AND;
                FN_OR:           alu_op = ALU_OR;
                FN_XOR:          alu_op = ALU_XOR;
                FN_NOR:          alu_op = ALU_NOR;
                FN_SLT:          alu_op = ALU_slt;
                FN_SLTU:         alu_op = ALU_sltu;
                FN_SLL:          alu_op = ALU_sll;
                FN_SRL:          alu_op = ALU_srl;
                FN_SRA:          alu_op = ALU_sra;
                FN_SYSCALL, FN_JR: alu_op = 4'h0;
                FN_MFHI: begin alu_op = ALU_rs_pass; dec_hilo = 1'b1; dec_mfhi = 1'b1; end
                FN_MFLO: begin alu_op = ALU_rs_pass; dec_hilo = 1'b1; dec_mflo = 1'b1; end
                FN_MTHI: begin alu_op = 4'h0; dec_hilo = 1'b1; dec_mthi = 1'b1; end
                FN_MTLO: begin alu_op = 4'h0; dec_hilo = 1'b1; dec_mtlo = 1'b1; end
                FN_MULT:  begin alu_op = 4'h0; dec_hilo = 1'b1; dec_mul = 1'b1; dec_signed = 1'b1; end
                FN_MULTU: begin alu_op = 4'h0; dec_hilo = 1'b1; dec_mul = 1'b1; end
                FN_DIV:   begin alu_op = 4'h0; dec_hilo = 1'b1; dec_div = 1'b1; dec_signed = 1'b1; end
                FN_DIVU:  begin alu_op = 4'h0; dec_hilo = 1'b1; dec_div = 1'b1; end
                default:  alu_op = ALU_undef;
            endcase
        end else begin
            case (opcode)
                OP_LW, OP_LB, OP_SW, OP_SB, OP_ADDI, OP_ADDIU: alu_op = ALU_add;
                OP_ANDI:  alu_op = ALU_AND;
                OP_ORI:   alu_op = ALU_OR;
                OP_XORI:  alu_op = ALU_XOR;
                OP_SLTI:  alu_op = ALU_slt;
                OP_SLTIU: alu_op = ALU_sltu;
                OP_LUI:   alu_op = ALU_slli;
                default:  alu_op = ALU_undef;
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign stall  = busy && issue && dec_hilo;
    assign accept = issue && !stall;

    // Sequencer datapath works on magnitudes; signs are restored in FIX.
    logic [WIDTH-1:0]   rs_abs, rt_abs, mul_addend, quot_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;

    assign rs_abs     = (dec_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign rt_abs     = (dec_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    assign mul_addend = a_q[0] ? b_q : '0;
    assign mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
    assign div_shift  = {acc_q, a_q[WIDTH-1]};
    assign div_trial  = div_shift - {1'b0, b_q};
    assign prod_mag   = {acc_q, a_q};
    assign prod_fix   = neg_q ? -prod_mag : prod_mag;
    assign quot_fix   = neg_q ? -a_q : a_q;
    assign rem_fix    = rneg_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (dec_mul || dec_div)) begin
                    a_d     = rs_abs;
                    b_d     = rt_abs;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    div_d   = dec_div;
                    neg_d   = dec_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    rneg_d  = dec_signed && rs_data[WIDTH-1];
                    state_d = dec_div ? S_DIV : S_MUL;
                end
                if (accept && dec_mthi) hi_d = rs_data;
                if (accept && dec_mtlo) lo_d = rs_data;
            end
            S_MUL: begin
                // {acc, a} shifts right as one 2*WIDTH product register.
                acc_d = mul_sum[WIDTH:1];
                a_d   = {mul_sum[0], a_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                if (!div_trial[WIDTH]) begin
                    acc_d = div_trial[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (div_q) begin
                    // Zero divisor leaves |rs| in acc, so rem_fix reproduces rs.
                    lo_d = (b_q == '0) ? '1 : quot_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign div_zero   = (state_q == S_FIX) && div_q && (b_q == '0);
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign hilo_rdata = dec_mfhi ? hi_q : (dec_mflo ? lo_q : '0);

endmodule

// File: tb/tb_hilo_alu_control.sv
// tb/tb_hilo_alu_control.sv - self-checking bench for hilo_alu_control
module tb_hilo_alu_control;
    localparam int W = 32;

    localparam logic [3:0] A_UNDEF = 4'hF, A_ADD = 4'h1, A_SUB = 4'h2, A_AND = 4'h3,
                           A_OR = 4'h4, A_XOR = 4'h5, A_NOR = 4'h6, A_SLT = 4'h7,
                           A_SLTU = 4'h8, A_SLL = 4'h9, A_SRL = 4'hA, A_SRA = 4'hB,
                           A_PASS = 4'hC, A_SLLI = 4'hD;

    localparam logic [5:0] F_SLL = 6'h00, F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12,
                           F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A,
                           F_DIVU = 6'h1B, F_ADDU = 6'h21;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic [5:0]   opcode = '0;
    logic [5:0]   funct = '0;
    logic         issue = 1'b0;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic [3:0]   alu_op;
    logic         stall, busy, div_zero;
    logic [W-1:0] hilo_rdata, hi, lo;

    hilo_alu_control #(.WIDTH(W)) dut (
        .clk(clk), .rst_b(rst_b), .opcode(opcode), .funct(funct), .issue(issue),
        .rs_data(rs_data), .rt_data(rt_data), .alu_op(alu_op), .stall(stall),
        .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo), .busy(busy), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: return A_ADD;
                6'h22, 6'h23: return A_SUB;
                6'h24: return A_AND;
                6'h25: return A_OR;
                6'h26: return A_XOR;
                6'h27: return A_NOR;
                6'h2A: return A_SLT;
                6'h2B: return A_SLTU;
                6'h00: return A_SLL;
                6'h02: return A_SRL;
                6'h03: return A_SRA;
                6'h10, 6'h12: return A_PASS;
                6'h0C, 6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: return 4'h0;
                default: return A_UNDEF;
            endcase
        end
        case (op)
            6'h23, 6'h20, 6'h2B, 6'h28, 6'h08, 6'h09: return A_ADD;
            6'h0C: return A_AND;
            6'h0D: return A_OR;
            6'h0E: return A_XOR;
            6'h0A: return A_SLT;
            6'h0B: return A_SLTU;
            6'h0F: return A_SLLI;
            default: return A_UNDEF;
        endcase
    endfunction

    function automatic logic is_hilo(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'h00) && (fn inside {F_MFHI, F_MFLO, F_MTHI, F_MTLO,
                                            F_MULT, F_MULTU, F_DIV, F_DIVU});
    endfunction

    // {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] hilo_result(input logic [5:0] fn, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint q, r;
        case (fn)
            F_MULT:  return sa * sb;
            F_MULTU: return ua * ub;
            F_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         p_dz;
    int           m_cnt;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_hi  <= '0;
            m_lo  <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            p_dz  <= 1'b0;
            m_cnt <= 0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (issue && opcode == 6'h00) begin
            case (funct)
                F_MTHI: m_hi <= rs_data;
                F_MTLO: m_lo <= rs_data;
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    {p_hi, p_lo} <= hilo_result(funct, rs_data, rt_data);
                    p_dz  <= (funct inside {F_DIV, F_DIVU}) && (rt_data == 0);
                    m_cnt <= W + 1;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        check("alu_op", 64'(alu_op), 64'(exp_alu(opcode, funct)));
        check("busy", 64'(busy), 64'(m_cnt > 0));
        check("stall", 64'(stall), 64'((m_cnt > 0) && issue && is_hilo(opcode, funct)));
        check("div_zero", 64'(div_zero), 64'((m_cnt == 1) && p_dz));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        check("hilo_rdata", 64'(hilo_rdata),
              64'((opcode == 0 && funct == F_MFHI) ? m_hi :
                  (opcode == 0 && funct == F_MFLO) ? m_lo : '0));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        opcode = 6'h00; funct = fn; rs_data = a; rt_data = b; issue = 1'b1;
        step(1);
        issue = 1'b0; funct = F_SLL; rs_data = '0; rt_data = '0;
    endtask

    task automatic run_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        issue_op(fn, a, b);
        check({name, "_busy1"}, 64'(busy), 64'd1);
        step(W + 1);
        check({name, "_busy_end"}, 64'(busy), 64'd0);
        check({name, "_hi"}, 64'(hi), 64'(ehi));
        check({name, "_lo"}, 64'(lo), 64'(elo));
    endtask

    logic [5:0] vec_op[8] = '{6'h00, 6'h0D, 6'h3F, 6'h0F, 6'h23, 6'h0B, 6'h00, 6'h00};
    logic [5:0] vec_fn[8] = '{6'h21, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h27, 6'h3E};

    initial begin
        step(2);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_b = 1'b1;
        step(1);

        opcode = 6'h00; funct = F_ADDU; #1;
        check("dec_addu", 64'(alu_op), 64'h1);
        opcode = 6'h0D; #1;
        check("dec_ori", 64'(alu_op), 64'h4);
        opcode = 6'h3F; #1;
        check("dec_undef", 64'(alu_op), 64'hF);
        for (int i = 0; i < 8; i++) begin
            opcode = vec_op[i]; funct = vec_fn[i];
            step(1);
        end
        opcode = 6'h00; funct = F_SLL;

        issue_op(F_DIVU, 32'd100, 32'd7);
        check("divu_busy_c1", 64'(busy), 64'd1);
        step(32);
        check("divu_busy_c33", 64'(busy), 64'd1);
        step(1);
        check("divu_busy_c34", 64'(busy), 64'd0);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);

        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("mult", F_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);
        run_op("mult_big", F_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div_rem", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

        issue_op(F_MTHI, 32'hCAFE_0001, 32'h0);
        funct = F_MFHI; issue = 1'b1; #1;
        check("mfhi_after_mthi", 64'(hilo_rdata), 64'hCAFE_0001);
        step(1);
        issue = 1'b0; funct = F_SLL;

        issue_op(F_DIVU, 32'd5, 32'd0);
        funct = F_MFHI; issue = 1'b1; #1;
        check("dz_stall_c1", 64'(stall), 64'd1);
        step(4);
        funct = F_ADDU; #1;
        check("dz_addu_stall", 64'(stall), 64'd0);
        step(1);
        funct = F_MFHI;
        step(27);
        check("dz_pulse_c33", 64'(div_zero), 64'd1);
        check("dz_stall_c33", 64'(stall), 64'd1);
        step(1);
        check("dz_stall_c34", 64'(stall), 64'd0);
        check("dz_rdata_c34", 64'(hilo_rdata), 64'd5);
        check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        step(1);
        issue = 1'b0; funct = F_SLL;

        issue_op(F_DIV, 32'h1000, 32'd3);
        step(9);
        rst_b = 1'b0; #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        #2 rst_b = 1'b1;
        step(1);
        issue_op(F_MTLO, 32'h1234, 32'h0);
        check("mtlo_after_abort", 64'(lo), 64'h1234);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
